// File: rtl/io_bank.sv
// io_bank: memory-mapped LED/HEX/LCD/switch register bank with sticky error status
module io_bank #(
    parameter int NUM_HEX         = 8,
    parameter int LEDR_W          = 17,
    parameter int LEDG_W          = 8,
    parameter int SW_W            = 17,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LCD_EN_CYCLES   = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           addr,
    input  logic                 wr_en,
    input  logic [31:0]          wdata,
    input  logic                 rd_en,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    input  logic [SW_W-1:0]      sw_raw,
    output logic [7*NUM_HEX-1:0] hex_o,
    output logic [LEDR_W-1:0]    ledr_o,
    output logic [LEDG_W-1:0]    ledg_o,
    output logic [7:0]           lcd_data,
    output logic                 lcd_rw,
    output logic                 lcd_rs,
    output logic                 lcd_en,
    output logic                 lcd_on,
    output logic                 err_o
);
    localparam int CW = $clog2(LCD_EN_CYCLES + 1);
    localparam int PW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [31:0] LEDR_M = 32'((64'd1 << LEDR_W) - 64'd1);
    localparam logic [31:0] LEDG_M = 32'((64'd1 << LEDG_W) - 64'd1);
    localparam logic [31:0] MODE_M = 32'((64'd1 << NUM_HEX) - 64'd1);
    localparam logic [31:0] LCD_M  = 32'h8000_07FF;

    typedef enum logic {IDLE, PULSE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic [LEDG_W-1:0] ledg_q, ledg_d;
    logic [7:0]      lcd_data_q, lcd_data_d;
    logic            lcd_rw_q, lcd_rw_d, lcd_rs_q, lcd_rs_d;
    logic            lcd_enb_q, lcd_enb_d, lcd_on_q, lcd_on_d;
    logic [7:0]      mode_q, mode_d;
    logic [6:0]      hex_q [8];
    logic [6:0]      hex_d [8];
    logic [2:0]      status_q, status_d, set;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q;
    logic [SW_W-1:0] sync1_q, sync2_q, sample_q, sample_d, sw_q, sw_d, eq;
    logic [PW-1:0]   presc_q, presc_d;
    logic            is_hex, mapped, tick;
    logic [6:0]      hex_wm;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40; 4'h1: font = 7'h79; 4'h2: font = 7'h24; 4'h3: font = 7'h30;
            4'h4: font = 7'h19; 4'h5: font = 7'h12; 4'h6: font = 7'h02; 4'h7: font = 7'h78;
            4'h8: font = 7'h00; 4'h9: font = 7'h10; 4'hA: font = 7'h08; 4'hB: font = 7'h03;
            4'hC: font = 7'h46; 4'hD: font = 7'h21; 4'hE: font = 7'h06; default: font = 7'h0E;
        endcase
    endfunction

    assign is_hex = addr[4:3] == 2'b01 && int'(addr[2:0]) < NUM_HEX;
    assign mapped = addr <= 5'd5 || is_hex;
    assign hex_wm = mode_q[addr[2:0]] ? 7'h0F : 7'h7F;

    // Register writes, LCD pulse sequencing, read mux and sticky status
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        lcd_data_d = lcd_data_q;
        lcd_rw_d   = lcd_rw_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_enb_d  = lcd_enb_q;
        lcd_on_d   = lcd_on_q;
        mode_d     = mode_q;
        hex_d      = hex_q;
        set        = '0;
        if (state_q == PULSE) begin
            if (cnt_q == CW'(1)) begin
                state_d   = IDLE;
                lcd_enb_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        if (wr_en) begin
            if (!mapped || addr == 5'd5) begin
                set[1] = 1'b1;
            end else if (addr == 5'd0) begin
                ledr_d = wdata[LEDR_W-1:0];
                set[0] = |(wdata & ~LEDR_M);
            end else if (addr == 5'd1) begin
                ledg_d = wdata[LEDG_W-1:0];
                set[0] = |(wdata & ~LEDG_M);
            end else if (addr == 5'd2) begin
                if (state_q == PULSE) begin
                    set[2] = 1'b1;
                end else begin
                    {lcd_on_d, lcd_enb_d, lcd_rs_d, lcd_rw_d, lcd_data_d} = {wdata[31], wdata[10:0]};
                    set[0] = |(wdata & ~LCD_M);
                    if (wdata[10]) begin
                        state_d = PULSE;
                        cnt_d   = CW'(LCD_EN_CYCLES);
                    end
                end
            end else if (addr == 5'd3) begin
                mode_d = wdata[7:0] & MODE_M[7:0];
                set[0] = |(wdata & ~MODE_M);
            end else if (is_hex) begin
                hex_d[addr[2:0]] = wdata[6:0] & hex_wm;
                set[0] = |(wdata & ~{25'b0, hex_wm});
            end
        end
        if (rd_en && !mapped) set[1] = 1'b1;
        status_d = (status_q & ~(wr_en && addr == 5'd4 ? wdata[2:0] : 3'b0)) | set;
        rdata_d  = addr == 5'd0 ? 32'(ledr_q) :
                   addr == 5'd1 ? 32'(ledg_q) :
                   addr == 5'd2 ? {lcd_on_q, 20'b0, lcd_enb_q, lcd_rs_q, lcd_rw_q, lcd_data_q} :
                   addr == 5'd3 ? {24'b0, mode_q} :
                   addr == 5'd4 ? {29'b0, status_q} :
                   addr == 5'd5 ? 32'(sw_q) :
                   is_hex       ? {25'b0, hex_q[addr[2:0]]} : 32'b0;
    end

    // Switch debounce: a bit only moves when two consecutive tick samples agree
    always_comb begin
        tick     = presc_q == PW'(DEBOUNCE_CYCLES - 1);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        eq       = ~(sample_q ^ sync2_q);
        sw_d     = tick ? (sw_q & ~eq) | (sync2_q & eq) : sw_q;
        sample_d = tick ? sync2_q : sample_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ledr_q     <= '0;
            ledg_q     <= '0;
            lcd_data_q <= '0;
            lcd_rw_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_enb_q  <= 1'b0;
            lcd_on_q   <= 1'b0;
            mode_q     <= '0;
            for (int i = 0; i < 8; i++) hex_q[i] <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sample_q   <= '0;
            sw_q       <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            lcd_data_q <= lcd_data_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_enb_q  <= lcd_enb_d;
            lcd_on_q   <= lcd_on_d;
            mode_q     <= mode_d;
            hex_q      <= hex_d;
            status_q   <= status_d;
            rdata_q    <= rd_en ? rdata_d : rdata_q;
            rvalid_q   <= rd_en;
            sync1_q    <= sw_raw;
            sync2_q    <= sync1_q;
            sample_q   <= sample_d;
            sw_q       <= sw_d;
            presc_q    <= presc_d;
        end
    end

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        assign hex_o[7*g +: 7] = mode_q[g] ? font(hex_q[g][3:0]) : ~hex_q[g];
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign ledr_o   = ledr_q;
    assign ledg_o   = ledg_q;
    assign lcd_data = lcd_data_q;
    assign lcd_rw   = lcd_rw_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_en   = state_q == PULSE;
    assign lcd_on   = lcd_on_q;
    assign err_o    = |status_q;
endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: vector table, directed LCD/debounce/reset sequences and randomized model check for io_bank
module tb_io_bank;
    localparam int NH = 4, LW = 17, GW = 8, SWW = 17, DB = 4, LE = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       addr;
    logic             wr_en, rd_en, rvalid;
    logic [31:0]      wdata, rdata;
    logic [SWW-1:0]   sw_raw;
    logic [7*NH-1:0]  hex_o;
    logic [LW-1:0]    ledr_o;
    logic [GW-1:0]    ledg_o;
    logic [7:0]       lcd_data;
    logic             lcd_rw, lcd_rs, lcd_en, lcd_on, err_o;

    io_bank #(.NUM_HEX(NH), .LEDR_W(LW), .LEDG_W(GW), .SW_W(SWW),
              .DEBOUNCE_CYCLES(DB), .LCD_EN_CYCLES(LE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .sw_raw(sw_raw),
        .hex_o(hex_o), .ledr_o(ledr_o), .ledg_o(ledg_o), .lcd_data(lcd_data),
        .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_on(lcd_on), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model: register contents as plain words, pulse as cycles remaining
    logic [31:0] m_ledr, m_ledg, m_lcd, m_mode, m_sts;
    logic [31:0] m_hex [8];
    int          m_pulse;

    typedef struct {
        int          wr, rd, a;
        logic [31:0] d, rd_exp;
        int          err;
        logic [31:0] ledr, ledg, hex0;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input int wr, input int rd, input int a, input logic [31:0] d);
        wr_en = wr != 0;
        rd_en = rd != 0;
        addr  = 5'(a);
        wdata = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic m_reset();
        m_ledr = 0; m_ledg = 0; m_lcd = 0; m_mode = 0; m_sts = 0; m_pulse = 0;
        for (int i = 0; i < 8; i++) m_hex[i] = 0;
    endtask

    function automatic bit m_mapped(input int a);
        return a <= 5 || (a >= 8 && a < 8 + NH);
    endfunction

    function automatic logic [31:0] m_field(input int a);
        if (a == 0) return 32'((64'd1 << LW) - 1);
        if (a == 1) return 32'((64'd1 << GW) - 1);
        if (a == 3) return 32'((64'd1 << NH) - 1);
        return m_mode[a-8] ? 32'hF : 32'h7F;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return m_ledr;
        if (a == 1) return m_ledg;
        if (a == 2) return m_lcd;
        if (a == 3) return m_mode;
        if (a == 4) return m_sts;
        if (a >= 8 && a < 8 + NH) return m_hex[a-8];
        return 0;
    endfunction

    task automatic m_step(input int wr, input int rd, input int a, input logic [31:0] d);
        logic [31:0] s, f;
        bit busy;
        s = 0;
        busy = m_pulse > 0;
        if (busy) begin
            m_pulse--;
            if (m_pulse == 0) m_lcd[10] = 1'b0;
        end
        if (wr != 0) begin
            if (!m_mapped(a) || a == 5) s[1] = 1'b1;
            else if (a == 2) begin
                if (busy) s[2] = 1'b1;
                else begin
                    if ((d & 32'h8000_07FF) != d) s[0] = 1'b1;
                    m_lcd = d & 32'h8000_07FF;
                    if (d[10]) m_pulse = LE;
                end
            end else if (a != 4) begin
                f = m_field(a);
                if ((d & ~f) != 0) s[0] = 1'b1;
                if (a == 0) m_ledr = d & f;
                else if (a == 1) m_ledg = d & f;
                else if (a == 3) m_mode = d & f;
                else m_hex[a-8] = d & f;
            end
        end
        if (rd != 0 && !m_mapped(a)) s[1] = 1'b1;
        if (wr != 0 && a == 4) m_sts = m_sts & ~(d & 32'h7);
        m_sts = m_sts | s;
    endtask

    task automatic chk_model(input int rd, input logic [31:0] exp_rd);
        chk("m_ledr", 32'(ledr_o), m_ledr);
        chk("m_ledg", 32'(ledg_o), m_ledg);
        chk("m_lcd", {lcd_on, 20'b0, 1'b0, lcd_rs, lcd_rw, lcd_data}, m_lcd & 32'h8000_03FF);
        chk("m_lcd_en", 32'(lcd_en), 32'(m_pulse > 0));
        chk("m_err", 32'(err_o), 32'(m_sts != 0));
        for (int i = 0; i < NH; i++)
            chk($sformatf("m_hex%0d", i), 32'(hex_o[7*i +: 7]),
                m_mode[i] ? {25'b0, font[m_hex[i][3:0]]} : ~m_hex[i] & 32'h7F);
        chk("m_rvalid", 32'(rvalid), 32'(rd != 0));
        if (rd != 0) chk("m_rdata", rdata, exp_rd);
    endtask

    task automatic chk_reset();
        chk("rst_hex", 32'(hex_o), 32'h0FFF_FFFF);
        chk("rst_ledr", 32'(ledr_o), 0);
        chk("rst_ledg", 32'(ledg_o), 0);
        chk("rst_lcd", {20'b0, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data}, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi, bad, sel, a, wr, rd;
        logic [31:0] d, exp_rd;
        int alist [14];
        alist = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 15, 16, 31};
        reset = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; sw_raw = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        reset = 1'b0;

        tbl.push_back(vec_t'{1, 0, 0,    'h12345, 0,   0, 'h12345, 0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 0,    'h20000, 0,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{0, 1, 4,    0,       1,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 4,    1,       0,   0, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 3,    1,       0,   0, 0,       0,    'h40});
        tbl.push_back(vec_t'{1, 0, 8,    8,       0,   0, 0,       0,    'h00});
        tbl.push_back(vec_t'{1, 0, 3,    0,       0,   0, 0,       0,    'h77});
        tbl.push_back(vec_t'{1, 0, 8,    'h7F,    0,   0, 0,       0,    'h00});
        tbl.push_back(vec_t'{1, 0, 8,    0,       0,   0, 0,       0,    'h7F});
        tbl.push_back(vec_t'{0, 1, 31,   0,       0,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{0, 1, 4,    0,       2,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 4,    7,       0,   0, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 5,    'h123,   0,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 4,    2,       0,   0, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 12,   1,       0,   1, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 4,    7,       0,   0, 0,       0,    'h7F});
        tbl.push_back(vec_t'{1, 0, 3,    1,       0,   0, 0,       0,    'h40});
        tbl.push_back(vec_t'{1, 0, 8,    'h1F,    0,   1, 0,       0,    'h0E});
        tbl.push_back(vec_t'{0, 1, 8,    0,       'hF, 1, 0,       0,    'h0E});
        tbl.push_back(vec_t'{1, 0, 4,    1,       0,   0, 0,       0,    'h0E});
        tbl.push_back(vec_t'{1, 0, 1,    'h0F,    0,   0, 0,       'h0F, 'h0E});
        tbl.push_back(vec_t'{1, 1, 1,    'hF0,    'h0F,0, 0,       'hF0, 'h0E});
        tbl.push_back(vec_t'{1, 0, 1,    'h1FF,   0,   1, 0,       'hFF, 'h0E});
        tbl.push_back(vec_t'{1, 0, 4,    1,       0,   0, 0,       'hFF, 'h0E});
        tbl.push_back(vec_t'{0, 1, 3,    0,       1,   0, 0,       'hFF, 'h0E});
        tbl.push_back(vec_t'{1, 0, 3,    'h10,    0,   1, 0,       'hFF, 'h70});
        tbl.push_back(vec_t'{0, 1, 3,    0,       0,   1, 0,       'hFF, 'h70});
        tbl.push_back(vec_t'{1, 0, 4,    7,       0,   0, 0,       'hFF, 'h70});
        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            chk($sformatf("t%0d_err", i), 32'(err_o), 32'(tbl[i].err));
            chk($sformatf("t%0d_ledr", i), 32'(ledr_o), tbl[i].ledr);
            chk($sformatf("t%0d_ledg", i), 32'(ledg_o), tbl[i].ledg);
            chk($sformatf("t%0d_hex0", i), 32'(hex_o[6:0]), tbl[i].hex0);
            chk($sformatf("t%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rd));
            if (tbl[i].rd != 0) chk($sformatf("t%0d_rdata", i), rdata, tbl[i].rd_exp);
        end

        sw_raw = 17'h8;
        for (int n = 0; n < 14; n++) begin
            step(0, 1, 5, 0);
            if (rdata == 32'h8) break;
        end
        chk("sw_set", rdata, 32'h8);
        bad = 0;
        sw_raw = 17'h9;
        repeat (3) begin
            step(0, 1, 5, 0);
            bad = bad | int'(rdata[0]);
        end
        sw_raw = 17'h8;
        repeat (16) begin
            step(0, 1, 5, 0);
            bad = bad | int'(rdata[0]);
        end
        chk("sw_glitch", 32'(bad), 0);
        chk("sw_hold", rdata, 32'h8);

        step(1, 0, 2, 32'h8000_0641);
        chk("lcd_data", 32'(lcd_data), 32'h41);
        chk("lcd_rs_rw_on", {29'b0, lcd_rs, lcd_rw, lcd_on}, 32'b101);
        hi = lcd_en ? 1 : 0;
        for (int k = 0; k < 20 && lcd_en; k++) begin
            step(k == 1 ? 1 : 0, 0, 2, 32'h0000_0512);
            if (lcd_en) hi++;
        end
        chk("lcd_pulse_len", 32'(hi), LE);
        chk("lcd_busy_data", 32'(lcd_data), 32'h41);
        step(0, 1, 4, 0);
        chk("lcd_busy_sts", rdata, 32'h4);
        step(0, 1, 2, 0);
        chk("lcd_after", rdata, 32'h8000_0241);
        step(1, 0, 4, 7);
        step(1, 0, 2, 32'h0000_0155);
        chk("lcd_idle_en", 32'(lcd_en), 0);
        chk("lcd_idle_data", {22'b0, lcd_on, lcd_rw, lcd_data}, 32'h155);

        sw_raw = '0;
        step(1, 0, 2, 32'h0000_0400);
        chk("rstp_en", 32'(lcd_en), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstp_drop", 32'(lcd_en), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset();
        m_reset();

        for (int n = 0; n < 600; n++) begin
            a   = alist[$urandom_range(0, 13)];
            wr  = $urandom_range(0, 1);
            rd  = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            d   = $urandom;
            d   = sel == 1 ? d & 32'hFF : sel == 2 ? d & 32'h7FF : sel == 3 ? d & 32'h1FFFF : d;
            exp_rd = m_read(a);
            m_step(wr, rd, a, d);
            step(wr, rd, a, d);
            chk_model(rd, exp_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
